// File: rtl/sequencer.sv
// Micro-sequencer for the 8-bit processor: one FSM issues every bus/load/memory/ALU strobe.
// Memory ops (LOAD/STORE/ADD/SUB) take 6 cycles, BNE/NOP 4; free-running, no backpressure.
module sequencer #(
  parameter int OP_W = 3
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            Addr_bus,
  output logic            load_MAR,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            CS,
  output logic            R_NW,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            instr_done
);

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_mem_op;

  assign w_mem_op = (op == OP_LOAD) || (op == OP_STORE) ||
                    (op == OP_ADD)  || (op == OP_SUB);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = S0;
    ACC_bus    = 1'b0;
    load_ACC   = 1'b0;
    PC_bus     = 1'b0;
    load_PC    = 1'b0;
    INC_PC     = 1'b0;
    load_IR    = 1'b0;
    Addr_bus   = 1'b0;
    load_MAR   = 1'b0;
    MDR_bus    = 1'b0;
    load_MDR   = 1'b0;
    CS         = 1'b0;
    R_NW       = 1'b0;
    ALU_ACC    = 1'b0;
    ALU_add    = 1'b0;
    ALU_sub    = 1'b0;
    instr_done = 1'b0;

    case (r_state)
      S0: begin
        PC_bus   = 1'b1;
        load_MAR = 1'b1;
        w_next   = S1;
      end
      S1: begin
        CS      = 1'b1;
        R_NW    = 1'b1;
        load_PC = 1'b1;
        INC_PC  = 1'b1;
        w_next  = S2;
      end
      S2: begin
        MDR_bus = 1'b1;
        load_IR = 1'b1;
        w_next  = S3;
      end
      S3: begin
        if (w_mem_op) begin
          Addr_bus = 1'b1;
          load_MAR = 1'b1;
          w_next   = S4;
        end else begin
          // BNE branches when the accumulator is non-zero; NOP codes just retire
          if ((op == OP_BNE) && !z_flag) begin
            Addr_bus = 1'b1;
            load_PC  = 1'b1;
          end
          instr_done = 1'b1;
          w_next     = S0;
        end
      end
      S4: begin
        if (op == OP_STORE) begin
          ACC_bus  = 1'b1;
          load_MDR = 1'b1;
          w_next   = S5;
        end else if (w_mem_op) begin
          CS     = 1'b1;
          R_NW   = 1'b1;
          w_next = S5;
        end else begin
          w_next = S0;
        end
      end
      S5: begin
        // read data from the S4 strobe is on sysbus now
        case (op)
          OP_LOAD: begin
            MDR_bus  = 1'b1;
            ALU_ACC  = 1'b1;
            load_ACC = 1'b1;
          end
          OP_ADD: begin
            MDR_bus  = 1'b1;
            ALU_add  = 1'b1;
            load_ACC = 1'b1;
          end
          OP_SUB: begin
            MDR_bus  = 1'b1;
            ALU_sub  = 1'b1;
            load_ACC = 1'b1;
          end
          OP_STORE: begin
            CS   = 1'b1;
            R_NW = 1'b0;
          end
          default: ;
        endcase
        instr_done = 1'b1;
        w_next     = S0;
      end
      default: w_next = S0;
    endcase
  end

endmodule

// File: tb/tb_sequencer.sv
// Bench for sequencer: literal directed sequences, then a random opcode stream vs an instruction-level model.
module tb_sequencer;

  logic       clock;
  logic       n_reset;
  logic [2:0] op;
  logic       z_flag;
  logic ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR;
  logic MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add, ALU_sub, instr_done;

  sequencer #(.OP_W(3)) dut (
    .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag),
    .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
    .INC_PC(INC_PC), .load_IR(load_IR), .Addr_bus(Addr_bus), .load_MAR(load_MAR),
    .MDR_bus(MDR_bus), .load_MDR(load_MDR), .CS(CS), .R_NW(R_NW),
    .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .instr_done(instr_done)
  );

  localparam logic [15:0] M_ACC_BUS  = 16'h8000;
  localparam logic [15:0] M_LOAD_ACC = 16'h4000;
  localparam logic [15:0] M_PC_BUS   = 16'h2000;
  localparam logic [15:0] M_LOAD_PC  = 16'h1000;
  localparam logic [15:0] M_INC_PC   = 16'h0800;
  localparam logic [15:0] M_LOAD_IR  = 16'h0400;
  localparam logic [15:0] M_ADDR_BUS = 16'h0200;
  localparam logic [15:0] M_LOAD_MAR = 16'h0100;
  localparam logic [15:0] M_MDR_BUS  = 16'h0080;
  localparam logic [15:0] M_LOAD_MDR = 16'h0040;
  localparam logic [15:0] M_CS       = 16'h0020;
  localparam logic [15:0] M_R_NW     = 16'h0010;
  localparam logic [15:0] M_ALU_ACC  = 16'h0008;
  localparam logic [15:0] M_ALU_ADD  = 16'h0004;
  localparam logic [15:0] M_ALU_SUB  = 16'h0002;
  localparam logic [15:0] M_DONE     = 16'h0001;

  // hand-written literal vectors for the directed phase
  localparam logic [15:0] L_F0       = 16'h2100; // PC_bus, load_MAR
  localparam logic [15:0] L_F1       = 16'h1830; // load_PC, INC_PC, CS, R_NW
  localparam logic [15:0] L_F2       = 16'h0480; // load_IR, MDR_bus
  localparam logic [15:0] L_DEC      = 16'h0300; // Addr_bus, load_MAR
  localparam logic [15:0] L_RD       = 16'h0030; // CS, R_NW
  localparam logic [15:0] L_ST4      = 16'h8040; // ACC_bus, load_MDR
  localparam logic [15:0] L_ST5      = 16'h0021; // CS, done
  localparam logic [15:0] L_LD5      = 16'h4089; // load_ACC, MDR_bus, ALU_ACC, done
  localparam logic [15:0] L_ADD5     = 16'h4085; // load_ACC, MDR_bus, ALU_add, done
  localparam logic [15:0] L_SUB5     = 16'h4083; // load_ACC, MDR_bus, ALU_sub, done
  localparam logic [15:0] L_BR_TAKEN = 16'h1201; // load_PC, Addr_bus, done
  localparam logic [15:0] L_DONE     = 16'h0001;

  logic [15:0] obs;
  assign obs = {ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
                MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add, ALU_sub, instr_done};

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int done_exp = 0;
  int acc_in_abort = 0;
  bit abort_win = 1'b0;
  logic [15:0] exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction-level model: fetch is common, the tail depends only on opcode and zero flag.
  task automatic model_push(input logic [2:0] o, input logic z);
    exp_q.push_back(M_PC_BUS | M_LOAD_MAR);
    exp_q.push_back(M_CS | M_R_NW | M_LOAD_PC | M_INC_PC);
    exp_q.push_back(M_MDR_BUS | M_LOAD_IR);
    if (o <= 3'd3) begin
      exp_q.push_back(M_ADDR_BUS | M_LOAD_MAR);
      if (o == 3'd1) begin
        exp_q.push_back(M_ACC_BUS | M_LOAD_MDR);
        exp_q.push_back(M_CS | M_DONE);
      end else begin
        exp_q.push_back(M_CS | M_R_NW);
        exp_q.push_back(M_MDR_BUS | M_LOAD_ACC | M_DONE |
                        (o == 3'd0 ? M_ALU_ACC : (o == 3'd2 ? M_ALU_ADD : M_ALU_SUB)));
      end
    end else if (o == 3'd4 && !z) begin
      exp_q.push_back(M_ADDR_BUS | M_LOAD_PC | M_DONE);
    end else begin
      exp_q.push_back(M_DONE);
    end
  endtask

  // Called with the DUT in S0, just after an edge; returns at the next instruction's S0.
  task automatic run(input logic [2:0] o, input logic z, input int len);
    op = o;
    z_flag = z;
    repeat (len) @(posedge clock);
    #1;
    done_exp++;
  endtask

  task automatic lit6(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    exp_q.push_back(L_F0); exp_q.push_back(L_F1); exp_q.push_back(L_F2);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
  endtask

  task automatic lit4(input logic [15:0] a);
    exp_q.push_back(L_F0); exp_q.push_back(L_F1); exp_q.push_back(L_F2);
    exp_q.push_back(a);
  endtask

  always @(negedge clock) begin
    if (n_reset) begin
      if (exp_q.size() > 0) check("strobes", obs, exp_q.pop_front());
      check("bus_onehot", 16'($countones({ACC_bus, PC_bus, Addr_bus, MDR_bus}) <= 1), 16'd1);
      check("alu_onehot", 16'($countones({ALU_ACC, ALU_add, ALU_sub}) <= 1), 16'd1);
      check("inc_without_load", 16'(INC_PC & ~load_PC), 16'd0);
      if (instr_done) done_seen++;
    end
    if (abort_win && load_ACC) acc_in_abort++;
  end

  initial begin
    logic [2:0] ro;
    logic       rz;
    n_reset = 1'b0;
    op = 3'd0;
    z_flag = 1'b0;
    #2;
    check("reset_async", obs, L_F0);
    repeat (3) @(posedge clock);
    #1;
    check("reset_held", obs, L_F0);
    n_reset = 1'b1;

    // directed: STORE, ADD, SUB, BNE taken / not taken, NOP
    lit6(L_DEC, L_ST4, L_ST5);  run(3'd1, 1'b0, 6);
    lit6(L_DEC, L_RD, L_ADD5);  run(3'd2, 1'b1, 6);
    lit6(L_DEC, L_RD, L_SUB5);  run(3'd3, 1'b0, 6);
    lit6(L_DEC, L_RD, L_LD5);   run(3'd0, 1'b0, 6);
    lit4(L_BR_TAKEN);           run(3'd4, 1'b0, 4);
    lit4(L_DONE);               run(3'd4, 1'b1, 4);
    lit4(L_DONE);               run(3'd7, 1'b0, 4);
    lit4(L_DONE);               run(3'd5, 1'b1, 4);

    // reset abort in S4 of a LOAD
    exp_q.push_back(L_F0); exp_q.push_back(L_F1); exp_q.push_back(L_F2);
    exp_q.push_back(L_DEC); exp_q.push_back(L_RD);
    op = 3'd0;
    z_flag = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    #1;
    n_reset = 1'b0;
    abort_win = 1'b1;
    #1;
    check("abort_to_s0", obs, L_F0);
    check("abort_queue_drained", 16'(exp_q.size()), 16'd0);
    repeat (2) @(posedge clock);
    #1;
    n_reset = 1'b1;
    lit4(L_DONE);               run(3'd6, 1'b0, 4);
    abort_win = 1'b0;
    check("no_load_acc_after_abort", 16'(acc_in_abort), 16'd0);

    // random opcode stream against the model
    for (int i = 0; i < 1000; i++) begin
      ro = 3'($urandom_range(0, 7));
      rz = 1'($urandom_range(0, 1));
      model_push(ro, rz);
      run(ro, rz, (ro <= 3'd3) ? 6 : 4);
    end

    check("queue_empty_end", 16'(exp_q.size()), 16'd0);
    check("done_count", 16'(done_seen), 16'(done_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
